// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter must hold WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Start/done handshake and operand/product bus of the shared multiplier.
interface mult_seq_ctrl_if
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/mult_datapath.sv
// Registered add/shift datapath: accumulator plus shifting operand copies.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               lsb,
  output logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] sum_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    a_sh;
  logic [WIDTH-1:0] b_sh;

  // Accumulator plus the current partial product; cannot overflow PW bits.
  assign sum_c = acc + a_sh;
  assign lsb   = b_sh[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
    end else if (load) begin
      acc  <= '0;
      a_sh <= PW'(a);
      b_sh <= b;
    end else if (step) begin
      if (lsb) acc <= sum_c;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential multiplier controller: FSM, iteration count and product register.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic            clk,
  input logic            rst_n,
  mult_seq_ctrl_if.slave bus
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [PW-1:0]      product_q;
  logic               busy_q;
  logic               done_q;

  logic               load_c;
  logic               step_c;
  logic               last_c;
  logic               lsb;
  logic [PW-1:0]      acc;
  logic [PW-1:0]      sum_c;

  mult_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_c),
    .step  (step_c),
    .a     (bus.a),
    .b     (bus.b),
    .lsb   (lsb),
    .acc   (acc),
    .sum_c (sum_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    last_c = 1'b0;
    case (state_q)
      IDLE:    load_c = bus.start;
      RUN: begin
        step_c = 1'b1;
        last_c = (cnt_q == CNT_W'(1));
      end
      default: ;
    endcase
  end

  // Counter, product and handshake flags; flags follow the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (load_c)      cnt_q <= CNT_W'(WIDTH);
      else if (step_c) cnt_q <= cnt_q - CNT_W'(1);
      if (last_c) product_q <= lsb ? sum_c : acc;
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl against an arithmetic reference model.
module tb_mult_seq_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 2 * W;

  logic clk;
  logic rst_n;

  mult_seq_ctrl_if #(.WIDTH(W)) bus ();

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [PW-1:0] p;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            rem   = 0;
  logic [PW-1:0] pend_p = '0;
  logic [PW-1:0] m_prod = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: an accepted request keeps the unit busy W+1 cycles; product is a*b.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem    = 0;
      m_prod = '0;
      sb.delete();
    end else begin
      cyc++;
      if (rem == 0) begin
        if (bus.start) begin
          pend_p = PW'(bus.a) * PW'(bus.b);
          rem    = W + 1;
          sb.push_back('{p: pend_p, due: cyc + W});
        end
      end else begin
        rem--;
        if (rem == 1) m_prod = pend_p;
      end
    end
  end

  // Monitor: compare handshake and product every cycle, pop on each done.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 64'(bus.busy), 64'(rem != 0));
      chk("done", 64'(bus.done), 64'(rem == 1));
      chk("product", 64'(bus.product), 64'(m_prod));
      if (bus.done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done at cycle %0d: got done=1 want no pending op", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_product", 64'(bus.product), 64'(e.p));
          chk("latency", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout at cycle %0d: got busy=1 want 0", cyc);
    end
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #3;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_product", 64'(bus.product), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic, sweep and corners
    op(4'd3, 4'd3);
    for (int i = 0; i < 4; i++) op(W'(i), 4'd3);
    op(4'd15, 4'd15);
    op(4'd0, 4'd15);

    // Back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'd2;
    bus.b     = 4'd5;
    repeat (18) @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Start pulses during RUN and DONE must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd7; bus.b = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd1; bus.b = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Reset in the middle of RUN
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd5; bus.b = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_product", 64'(bus.product), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 64'(bus.done), 64'd0);
    end
    rst_n = 1'b1;
    op(4'd4, 4'd4);

    // Product holds while inputs wander with start low
    op(4'd3, 4'd4);
    repeat (10) begin
      @(negedge clk);
      bus.a = W'($urandom);
      bus.b = W'($urandom);
    end

    // Random operations with random gaps
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op(W'($urandom), W'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
